// File: rtl/line_bus_adapter.sv
// line_bus_adapter
//   Bridges a single-word request port (CPU / L1 side) to a cache-line-wide
//   memory port. One transaction is in flight at a time. A one-line read
//   buffer lets repeated reads to the same line complete without a line
//   fetch; writes go straight through to the line side and are merged into
//   the buffer when they hit the buffered line.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cpu_read/cpu_write  word request, held until cpu_resp (write has priority)
//   cpu_address         byte address
//   cpu_wdata           write word
//   cpu_byte_enable     write byte mask
//   cpu_rdata           read word, valid while cpu_resp is high
//   cpu_resp            one-cycle completion pulse
//   buf_inval           drops the line buffer valid bit
//   line_read/write     line-side request strobes (decoded from state)
//   line_address        line-aligned address of the latched request
//   line_wdata          latched write word replicated across the line
//   line_byte_enable    latched mask placed at the addressed word
//   line_rdata          line read data, valid with line_resp
//   line_resp           one-cycle completion pulse from the line side
module line_bus_adapter #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic [WORD_W-1:0]     cpu_wdata,
  input  logic [WORD_W/8-1:0]   cpu_byte_enable,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  cpu_resp,
  input  logic                  buf_inval,
  output logic                  line_read,
  output logic                  line_write,
  output logic [ADDR_W-1:0]     line_address,
  output logic [LINE_W-1:0]     line_wdata,
  output logic [LINE_W/8-1:0]   line_byte_enable,
  input  logic [LINE_W-1:0]     line_rdata,
  input  logic                  line_resp
);

  localparam int WORDS = LINE_W / WORD_W;
  localparam int WB    = WORD_W / 8;
  localparam int LB    = LINE_W / 8;
  localparam int OFF   = $clog2(LB);
  localparam int WOFF  = $clog2(WB);
  localparam int IDXW  = OFF - WOFF;
  localparam int TAGW  = ADDR_W - OFF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STORE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WB-1:0]       mask_q, mask_d;
  logic                buf_valid_q, buf_valid_d;
  logic [TAGW-1:0]     buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]   buf_data_q, buf_data_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic [IDXW-1:0]     cpu_idx_s, lat_idx_s;
  logic [TAGW-1:0]     cpu_tag_s, lat_tag_s;
  logic                cpu_hit_s;
  logic [LINE_W-1:0]   wline_s;
  logic [LB-1:0]       be_s;

  // Select one word of a line by word index.
  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [IDXW-1:0]   idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IDXW'(k)) w = line[k*WORD_W +: WORD_W];
    end
    return w;
  endfunction

  // Overwrite only the enabled bytes of a line.
  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] old_line,
                                                   input logic [LINE_W-1:0] new_line,
                                                   input logic [LB-1:0]     be);
    logic [LINE_W-1:0] m;
    m = old_line;
    for (int b = 0; b < LB; b++) begin
      if (be[b]) m[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return m;
  endfunction

  assign cpu_idx_s = cpu_address[OFF-1:WOFF];
  assign cpu_tag_s = cpu_address[ADDR_W-1:OFF];
  assign lat_idx_s = addr_q[OFF-1:WOFF];
  assign lat_tag_s = addr_q[ADDR_W-1:OFF];
  // An invalidate sampled with the request forces a miss.
  assign cpu_hit_s = buf_valid_q && (cpu_tag_s == buf_tag_q) && !buf_inval;
  assign wline_s   = {WORDS{wdata_q}};
  assign be_s      = LB'(mask_q) << (32'(lat_idx_s) * WB);

  // Moore outputs; data outputs come from the latched request.
  assign cpu_rdata        = rdata_q;
  assign cpu_resp         = (state_q == S_RESP);
  assign line_read        = (state_q == S_FETCH);
  assign line_write       = (state_q == S_STORE);
  assign line_address     = {lat_tag_s, {OFF{1'b0}}};
  assign line_wdata       = wline_s;
  assign line_byte_enable = (state_q == S_STORE) ? be_s : '0;

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    rdata_d    = rdata_q;
    if (buf_inval) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_write) begin
          addr_d  = cpu_address;
          wdata_d = cpu_wdata;
          mask_d  = cpu_byte_enable;
          state_d = S_STORE;
        end else if (cpu_read) begin
          if (cpu_hit_s) begin
            rdata_d = get_word(buf_data_q, cpu_idx_s);
            state_d = S_RESP;
          end else begin
            addr_d  = cpu_address;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (line_resp) begin
          // The fetched word is returned even if an invalidate races the fill.
          buf_data_d  = line_rdata;
          buf_tag_d   = lat_tag_s;
          buf_valid_d = !buf_inval;
          rdata_d     = get_word(line_rdata, lat_idx_s);
          state_d     = S_RESP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_STORE: begin
        if (line_resp) begin
          if (buf_valid_q && (lat_tag_s == buf_tag_q) && !buf_inval) begin
            buf_data_d = merge_line(buf_data_q, wline_s, be_s);
          end else begin
            buf_data_d = buf_data_q;
          end
          state_d = S_RESP;
        end else begin
          state_d = S_STORE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_line_bus_adapter.sv
// Self-checking bench for line_bus_adapter (32/256 default instance plus a
// 64/512 instance for the wide-parameter byte-enable check).
module tb_line_bus_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0]  cpu_address = 32'h0, cpu_wdata = 32'h0;
  logic [3:0]   cpu_byte_enable = 4'h0;
  logic [31:0]  cpu_rdata;
  logic         cpu_resp;
  logic         buf_inval = 1'b0;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [31:0]  line_byte_enable;
  logic [255:0] line_rdata = 256'h0;
  logic         line_resp = 1'b0;

  // wide instance signals
  logic         p_write = 1'b0;
  logic [31:0]  p_address = 32'h0;
  logic [63:0]  p_wdata = 64'h0;
  logic [7:0]   p_be = 8'h0;
  logic [63:0]  p_rdata;
  logic         p_resp, p_line_read, p_line_write, p_line_resp = 1'b0;
  logic [31:0]  p_line_address;
  logic [511:0] p_line_wdata;
  logic [63:0]  p_line_be;

  int checks = 0;
  int errors = 0;

  // reference model of the line buffer
  bit          mvalid = 1'b0;
  logic [26:0] mtag = 27'h0;
  logic [31:0] mline [8];

  always #5 clk = ~clk;

  line_bus_adapter dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_byte_enable(cpu_byte_enable),
    .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp), .buf_inval(buf_inval),
    .line_read(line_read), .line_write(line_write), .line_address(line_address),
    .line_wdata(line_wdata), .line_byte_enable(line_byte_enable),
    .line_rdata(line_rdata), .line_resp(line_resp)
  );

  line_bus_adapter #(.WORD_W(64), .LINE_W(512), .ADDR_W(32)) dut_w (
    .clk(clk), .rst(rst),
    .cpu_read(1'b0), .cpu_write(p_write), .cpu_address(p_address),
    .cpu_wdata(p_wdata), .cpu_byte_enable(p_be),
    .cpu_rdata(p_rdata), .cpu_resp(p_resp), .buf_inval(1'b0),
    .line_read(p_line_read), .line_write(p_line_write), .line_address(p_line_address),
    .line_wdata(p_line_wdata), .line_byte_enable(p_line_be),
    .line_rdata(512'h0), .line_resp(p_line_resp)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read transaction; pat selects the fixed word pattern k*0x11111111.
  task automatic do_read(input logic [31:0] a, input bit pat, input bit inv_s, input bit inv_r);
    bit hit;
    int idx;
    logic [31:0] exp;
    logic [31:0] w [8];
    idx = int'(a[4:2]);
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = a; buf_inval = inv_s;
    hit = mvalid && (a[31:5] == mtag) && !inv_s;
    if (inv_s) mvalid = 1'b0;
    @(negedge clk);
    buf_inval = 1'b0;
    if (hit) begin
      chk("hit_no_line_read", {511'h0, line_read}, 512'h0);
      chk("hit_resp", {511'h0, cpu_resp}, 512'h1);
      chk("hit_rdata", {480'h0, cpu_rdata}, {480'h0, mline[idx]});
    end else begin
      chk("miss_line_read", {511'h0, line_read}, 512'h1);
      chk("miss_line_addr", {480'h0, line_address}, {480'h0, a & 32'hFFFF_FFE0});
      chk("miss_no_resp", {511'h0, cpu_resp}, 512'h0);
      repeat ($urandom_range(2, 0)) begin
        @(negedge clk);
        chk("fetch_hold", {479'h0, line_read, line_address}, {479'h0, 1'b1, a & 32'hFFFF_FFE0});
      end
      for (int k = 0; k < 8; k++) begin
        w[k] = pat ? (32'h1111_1111 * k) : $urandom;
        line_rdata[k*32 +: 32] = w[k];
      end
      line_resp = 1'b1; buf_inval = inv_r;
      @(negedge clk);
      line_resp = 1'b0; buf_inval = 1'b0;
      line_rdata = {8{$urandom}};
      for (int k = 0; k < 8; k++) mline[k] = w[k];
      mtag = a[31:5];
      mvalid = !inv_r;
      exp = w[idx];
      chk("miss_resp", {511'h0, cpu_resp}, 512'h1);
      chk("miss_rdata", {480'h0, cpu_rdata}, {480'h0, exp});
    end
    cpu_read = 1'b0;
    @(negedge clk);
    chk("read_resp_one_cycle", {511'h0, cpu_resp}, 512'h0);
  endtask

  // Write transaction; rd_too also raises cpu_read to exercise priority.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input bit rd_too, input bit inv_r);
    int idx;
    logic [31:0]  exp_be;
    logic [255:0] exp_wd;
    idx = int'(a[4:2]);
    for (int b = 0; b < 32; b++) exp_be[b] = (b / 4 == idx) && m[b % 4];
    for (int k = 0; k < 8; k++) exp_wd[k*32 +: 32] = d;
    @(negedge clk);
    cpu_write = 1'b1; cpu_read = rd_too; cpu_address = a; cpu_wdata = d; cpu_byte_enable = m;
    @(negedge clk);
    chk("wr_line_write", {510'h0, line_write, line_read}, {510'h0, 2'b10});
    chk("wr_line_addr", {480'h0, line_address}, {480'h0, a & 32'hFFFF_FFE0});
    chk("wr_byte_enable", {480'h0, line_byte_enable}, {480'h0, exp_be});
    chk("wr_line_wdata", {256'h0, line_wdata}, {256'h0, exp_wd});
    repeat ($urandom_range(2, 0)) @(negedge clk);
    line_resp = 1'b1; buf_inval = inv_r;
    @(negedge clk);
    line_resp = 1'b0; buf_inval = 1'b0;
    if (mvalid && (a[31:5] == mtag) && !inv_r) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) mline[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    if (inv_r) mvalid = 1'b0;
    chk("wr_resp", {511'h0, cpu_resp}, 512'h1);
    cpu_write = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    chk("wr_resp_one_cycle", {510'h0, cpu_resp, line_write}, 512'h0);
  endtask

  initial begin
    logic [31:0] lines [3];
    logic [31:0] a;
    lines[0] = 32'h0000_0040; lines[1] = 32'h0000_0060; lines[2] = 32'hFFFF_FFE0;
    for (int k = 0; k < 8; k++) mline[k] = 32'h0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", {509'h0, cpu_resp, line_read, line_write}, 512'h0);
    chk("rst_data", {416'h0, cpu_rdata, line_address, line_byte_enable}, 512'h0);
    chk("rst_wdata", {256'h0, line_wdata}, 512'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctrl", {509'h0, cpu_resp, line_read, line_write}, 512'h0);
    chk("post_rst_data", {416'h0, cpu_rdata, line_address, line_byte_enable}, 512'h0);

    // miss, hit, write merge, hit after merge
    do_read(32'h0000_0048, 1'b1, 1'b0, 1'b0);
    do_read(32'h0000_004C, 1'b1, 1'b0, 1'b0);
    do_write(32'h0000_0044, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0);
    do_read(32'h0000_0044, 1'b1, 1'b0, 1'b0);

    // invalidate racing a fill, then the same line misses again
    do_read(32'h0000_0060, 1'b0, 1'b0, 1'b1);
    do_read(32'h0000_0064, 1'b0, 1'b0, 1'b0);
    do_read(32'h0000_0068, 1'b0, 1'b1, 1'b0);

    // read and write together: the write path is taken
    do_write(32'h0000_0070, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0);
    do_read(32'h0000_0070, 1'b0, 1'b0, 1'b0);

    // reset during FETCH
    @(negedge clk);
    cpu_read = 1'b1; cpu_address = 32'h0000_0048;
    @(negedge clk);
    chk("pre_rst_fetch", {511'h0, line_read}, 512'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_line_read", {510'h0, line_read, cpu_resp}, 512'h0);
    chk("rst_clears_rdata", {480'h0, cpu_rdata}, 512'h0);
    cpu_read = 1'b0;
    mvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    line_resp = 1'b1;
    @(negedge clk);
    line_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_line_resp_ignored", {510'h0, cpu_resp, line_read}, 512'h0);
    end
    do_read(32'h0000_004C, 1'b0, 1'b0, 1'b0);

    // randomized traffic over a few lines, including the top of memory
    for (int t = 0; t < 40; t++) begin
      a = lines[$urandom_range(2, 0)] | ($urandom & 32'h1F);
      if ($urandom_range(9, 0) < 6)
        do_read(a, 1'b0, ($urandom_range(9, 0) == 0), ($urandom_range(9, 0) == 0));
      else
        do_write(a, $urandom, 4'($urandom), 1'b0, ($urandom_range(9, 0) == 0));
    end

    // wide instance: write to word 7 with a full mask
    @(negedge clk);
    p_write = 1'b1; p_address = 32'h0000_0038; p_wdata = 64'h0123_4567_89AB_CDEF; p_be = 8'hFF;
    @(negedge clk);
    chk("wide_line_write", {511'h0, p_line_write}, 512'h1);
    chk("wide_byte_enable", {448'h0, p_line_be}, {448'h0, 64'hFF00_0000_0000_0000});
    chk("wide_line_wdata", p_line_wdata, {8{64'h0123_4567_89AB_CDEF}});
    p_line_resp = 1'b1;
    @(negedge clk);
    p_line_resp = 1'b0;
    chk("wide_resp", {511'h0, p_resp}, 512'h1);
    p_write = 1'b0;
    @(negedge clk);
    chk("wide_resp_one_cycle", {511'h0, p_resp}, 512'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_bus_adapter.md
Name: line_bus_adapter

Overview:
- Parametrised, sequential successor to the combinational word/line bus adapter.
- Bridges a single-word request interface (CPU or L1 side) to a cache-line-wide memory interface.
- Runs one transaction at a time under an FSM and holds a one-line read buffer, so back-to-back reads to the same line complete without a line fetch.
- Writes are write-through and are merged into the buffer when the line matches.

Parameters:
WORD_W, 32, word width in bits; multiple of 8.
LINE_W, 256, line width in bits; power-of-two multiple of WORD_W.
ADDR_W, 32, byte address width.
Derived constants (not overridable): WORDS=LINE_W/WORD_W, WB=WORD_W/8, LB=LINE_W/8, OFF=log2(LB), WOFF=log2(WB).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
cpu_read  in  1  word read request; held until cpu_resp.
cpu_write  in  1  word write request; held until cpu_resp.
cpu_address  in  ADDR_W  byte address.
cpu_wdata  in  WORD_W  write data.
cpu_byte_enable  in  WB  write byte mask.
cpu_rdata  out  WORD_W  read data; valid while cpu_resp=1.
cpu_resp  out  1  one-cycle completion pulse.
buf_inval  in  1  clears the line buffer valid bit.
line_read  out  1  line read request.
line_write  out  1  line write request.
line_address  out  ADDR_W  line-aligned address; low OFF bits are 0.
line_wdata  out  LINE_W  write data line.
line_byte_enable  out  LB  line byte mask.
line_rdata  in  LINE_W  read data line; valid with line_resp.
line_resp  in  1  one-cycle completion pulse from the line side.

Behaviour:
- Reset: state=IDLE; buf_valid=0; the latched request, buf_tag, buf_data and cpu_rdata are all zero.
  - All outputs are 0 while rst is high and in the first cycle after release.
  - Reset mid-transaction abandons any outstanding line request; a late line_resp in IDLE is ignored.
- Index fields:
  - word index: idx = addr[OFF-1:WOFF]; address bits below WOFF are ignored.
  - line tag: addr[ADDR_W-1:OFF].
- FSM states: IDLE, FETCH, STORE, RESP.
- IDLE samples the request. If cpu_read and cpu_write are both high, write has priority.
  - Write: latch address, data and mask; go to STORE.
  - Read hit (buf_valid && tag match && !buf_inval): cpu_rdata <= buf_data word[idx]; go to RESP.
  - Read miss: latch address; go to FETCH.
- FETCH:
  - line_read=1 and line_address held stable until line_resp.
  - On line_resp: buf_data <= line_rdata; buf_tag <= tag; buf_valid <= 1; cpu_rdata <= line_rdata word[idx]; go to RESP.
- STORE:
  - line_write=1.
  - line_wdata = the latched wdata replicated WORDS times.
  - line_byte_enable = zero-extended latched mask shifted left by idx*WB.
  - On line_resp: if buf_valid and tag match, overwrite only the enabled bytes of buf_data; go to RESP.
- RESP: cpu_resp=1 for exactly one cycle, then IDLE. The requester deasserts its request at the same edge.
- line_read, line_write and cpu_resp decode from state only (Moore). line_address comes from the latched address.
- Latency:
  - Read hit: cpu_resp in the 2nd cycle after the request is first high (sample + RESP).
  - Miss or write: cpu_resp in the cycle after line_resp.
  - Minimum spacing between two transactions is 1 idle cycle.
- buf_inval:
  - Clears buf_valid at the next edge.
  - If it coincides with a FETCH line_resp, the invalidate wins (buf_valid=0), but cpu_rdata still returns the fetched word.
  - If it coincides with the STORE merge, the merge is dropped.
  - An IDLE read sampled together with buf_inval is treated as a miss.
- Address wrap: tag compare covers the full upper address bits; there is no aliasing at the maximum address.

Test Plan:
- Reset then read miss: read 0x0000_0048, line_rdata word k = 0x1111_1111*k → line_read with line_address 0x0000_0040; after line_resp, cpu_rdata=0x2222_2222 with a one-cycle cpu_resp.
- Hit path: repeat read 0x0000_004C → no line_read; cpu_resp on the 2nd cycle; cpu_rdata=0x3333_3333.
- Write merge: write 0x0000_0044, data 0xDEAD_BEEF, mask 4'b0011 → line_byte_enable=32'h0000_0030, line_wdata=8×0xDEADBEEF; then read 0x44 hits and returns 0x1111_BEEF.
- Invalidate race: assert buf_inval on the same cycle as the FETCH line_resp → cpu_rdata is still correct; the next same-line read issues line_read.
- Priority and reset: cpu_read and cpu_write both high → STORE path taken. Then assert rst during FETCH → line_read drops immediately, buf_valid=0, and a subsequent stray line_resp produces no cpu_resp.
- Parameter sweep: WORD_W=64, LINE_W=512, write to word 7 with mask 8'hFF → line_byte_enable bits [63:56] set.
